// File: rtl/vote_pkg.sv
// Shared types and constants for the 4-voter ballot collector.
package vote_pkg;

    localparam int unsigned NUM_VOTERS = 4;

    localparam logic [2:0] RES_PASS = 3'b100;
    localparam logic [2:0] RES_TIE  = 3'b010;
    localparam logic [2:0] RES_FAIL = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/vote_collector_if.sv
// Ballot handshake and result bus between the collector (slave) and its environment (master).
interface vote_collector_if;
    import vote_pkg::*;

    logic                  start;
    logic                  ballot_valid;
    logic                  ballot_ready;
    logic [1:0]            ballot_id;
    logic                  ballot_yes;
    logic [NUM_VOTERS-1:0] votes;
    logic [NUM_VOTERS-1:0] cast;
    logic [2:0]            result;
    logic                  result_valid;
    logic                  result_ack;
    logic                  busy;
    logic                  dup_err;

    modport master (
        output start, ballot_valid, ballot_id, ballot_yes, result_ack,
        input  ballot_ready, votes, cast, result, result_valid, busy, dup_err
    );

    modport slave (
        input  start, ballot_valid, ballot_id, ballot_yes, result_ack,
        output ballot_ready, votes, cast, result, result_valid, busy, dup_err
    );

endinterface

// File: rtl/vote_decide.sv
// Combinational majority decision: popcount of the vote vector mapped to pass/tie/fail.
module vote_decide
    import vote_pkg::*;
(
    input  logic [NUM_VOTERS-1:0] i_votes,
    output logic [2:0]            o_result
);

    logic [2:0] w_yes;

    always_comb begin
        w_yes = '0;
        for (int i = 0; i < NUM_VOTERS; i++) begin
            w_yes = w_yes + 3'(i_votes[i]);
        end
        if (w_yes >= 3'd3) begin
            o_result = RES_PASS;
        end else if (w_yes == 3'd2) begin
            o_result = RES_TIE;
        end else begin
            o_result = RES_FAIL;
        end
    end

endmodule

// File: rtl/vote_collector.sv
// Collects one ballot per voter over valid/ready, closes on full turnout or timeout,
// then holds the frozen ballots and decision until acknowledged.
module vote_collector
    import vote_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    vote_collector_if.slave bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_VOTERS-1:0] r_votes;
    logic [NUM_VOTERS-1:0] r_cast;
    logic [2:0]            r_result;
    logic                  r_dup;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_accept;
    logic                  w_new;
    logic                  w_full;
    logic                  w_timeout;
    logic [NUM_VOTERS-1:0] w_id_oh;
    logic [NUM_VOTERS-1:0] w_cast_nxt;
    logic [2:0]            w_result;

    assign w_accept   = bus.ballot_valid && (r_state == COLLECT);
    assign w_id_oh    = NUM_VOTERS'(1) << bus.ballot_id;
    assign w_new      = w_accept && ((r_cast & w_id_oh) == '0);
    assign w_cast_nxt = w_new ? (r_cast | w_id_oh) : r_cast;
    assign w_full     = (w_cast_nxt == '1);
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    vote_decide u_decide (
        .i_votes  (r_votes),
        .o_result (w_result)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_nxt = COLLECT;
            COLLECT: if (w_full || w_timeout) w_state_nxt = DECIDE;
            DECIDE:  w_state_nxt = HOLD;
            HOLD:    if (bus.result_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_votes  <= '0;
            r_cast   <= '0;
            r_result <= '0;
            r_dup    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // A repeat ballot is dropped but flagged in the following cycle.
            r_dup <= w_accept && !w_new;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_votes <= '0;
                        r_cast  <= '0;
                        r_cnt   <= '0;
                    end
                end
                COLLECT: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_cast <= w_cast_nxt;
                    if (w_new) begin
                        r_votes[bus.ballot_id] <= bus.ballot_yes;
                    end
                end
                DECIDE:  r_result <= w_result;
                default: ;
            endcase
        end
    end

    assign bus.votes        = r_votes;
    assign bus.cast         = r_cast;
    assign bus.result       = r_result;
    assign bus.dup_err      = r_dup;
    assign bus.ballot_ready = (r_state == COLLECT);
    assign bus.result_valid = (r_state == HOLD);
    assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_vote_collector.sv
// Directed and randomized polls checked against a per-voter ballot-box model.
module tb_vote_collector;

    localparam int unsigned T = 16;

    typedef struct {
        bit       v;
        bit [1:0] id;
        bit       yes;
    } offer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    offer_t     plan[$];
    bit   [3:0] m_cast;
    bit   [3:0] m_votes;
    logic [3:0] dec_in;
    logic [2:0] dec_out;

    vote_collector_if vif ();

    vote_collector #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (vif)
    );

    vote_decide u_ref_dec (
        .i_votes  (dec_in),
        .o_result (dec_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] model_result(input bit [3:0] v);
        int yes = 0;
        for (int i = 0; i < 4; i++) yes += int'(v[i]);
        if (yes >= 3) return 3'b100;
        if (yes == 2) return 3'b010;
        return 3'b001;
    endfunction

    task automatic idle_inputs();
        vif.start        = 1'b0;
        vif.ballot_valid = 1'b0;
        vif.ballot_id    = 2'd0;
        vif.ballot_yes   = 1'b0;
        vif.result_ack   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".votes"}, 32'(vif.votes), 0);
        check({tag, ".cast"}, 32'(vif.cast), 0);
        check({tag, ".result"}, 32'(vif.result), 0);
        check({tag, ".rvalid"}, 32'(vif.result_valid), 0);
        check({tag, ".ready"}, 32'(vif.ballot_ready), 0);
        check({tag, ".busy"}, 32'(vif.busy), 0);
        check({tag, ".dup"}, 32'(vif.dup_err), 0);
    endtask

    // Consumes plan (one entry per collect cycle), then holds for hold_cycles with noise.
    task automatic run_poll(input string tag, input int hold_cycles);
        bit     done;
        bit     exp_dup;
        offer_t o;
        m_cast  = '0;
        m_votes = '0;
        vif.start = 1'b1;
        tick();
        vif.start = 1'b0;
        check({tag, ".open.busy"}, 32'(vif.busy), 1);
        check({tag, ".open.ready"}, 32'(vif.ballot_ready), 1);
        check({tag, ".open.cast"}, 32'(vif.cast), 0);
        check({tag, ".open.votes"}, 32'(vif.votes), 0);
        done = 1'b0;
        for (int c = 0; c < int'(T) && !done; c++) begin
            o = '{v: 1'b0, id: 2'd0, yes: 1'b0};
            if (plan.size() > 0) o = plan.pop_front();
            vif.ballot_valid = o.v;
            vif.ballot_id    = o.id;
            vif.ballot_yes   = o.yes;
            tick();
            vif.ballot_valid = 1'b0;
            exp_dup = 1'b0;
            if (o.v) begin
                if (m_cast[o.id]) begin
                    exp_dup = 1'b1;
                end else begin
                    m_cast[o.id]  = 1'b1;
                    m_votes[o.id] = o.yes;
                end
            end
            done = (m_cast == 4'hF) || (c == int'(T) - 1);
            check({tag, ".dup"}, 32'(vif.dup_err), 32'(exp_dup));
            check({tag, ".cast"}, 32'(vif.cast), 32'(m_cast));
            check({tag, ".ready"}, 32'(vif.ballot_ready), 32'(!done));
        end
        plan.delete();
        check({tag, ".decide.rvalid"}, 32'(vif.result_valid), 0);
        check({tag, ".decide.busy"}, 32'(vif.busy), 1);
        tick();
        check({tag, ".hold.rvalid"}, 32'(vif.result_valid), 1);
        check({tag, ".hold.votes"}, 32'(vif.votes), 32'(m_votes));
        check({tag, ".hold.cast"}, 32'(vif.cast), 32'(m_cast));
        check({tag, ".hold.result"}, 32'(vif.result), 32'(model_result(m_votes)));
        for (int h = 0; h < hold_cycles; h++) begin
            vif.ballot_valid = 1'b1;
            vif.ballot_id    = 2'($urandom_range(0, 3));
            vif.ballot_yes   = 1'($urandom_range(0, 1));
            vif.start        = 1'b1;
            tick();
            check({tag, ".stall.rvalid"}, 32'(vif.result_valid), 1);
            check({tag, ".stall.dup"}, 32'(vif.dup_err), 0);
            check({tag, ".stall.votes"}, 32'(vif.votes), 32'(m_votes));
            check({tag, ".stall.cast"}, 32'(vif.cast), 32'(m_cast));
            check({tag, ".stall.result"}, 32'(vif.result), 32'(model_result(m_votes)));
        end
        idle_inputs();
        vif.result_ack = 1'b1;
        tick();
        vif.result_ack = 1'b0;
        check({tag, ".ack.rvalid"}, 32'(vif.result_valid), 0);
        check({tag, ".ack.busy"}, 32'(vif.busy), 0);
        check({tag, ".ack.ready"}, 32'(vif.ballot_ready), 0);
    endtask

    task automatic add(input bit v, input bit [1:0] id, input bit yes);
        plan.push_back('{v: v, id: id, yes: yes});
    endtask

    initial begin
        idle_inputs();
        dec_in = '0;

        // Majority function over every ballot vector.
        for (int i = 0; i < 16; i++) begin
            dec_in = 4'(i);
            #1;
            check("decide", 32'(dec_out), 32'(model_result(4'(i))));
        end

        #3;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        add(1, 0, 1); add(1, 1, 1); add(1, 2, 0); add(1, 3, 1);
        run_poll("full", 5);
        check("full.votes_const", 32'(m_votes), 32'(4'b1011));

        add(1, 0, 1); add(1, 1, 0); add(1, 2, 1); add(1, 3, 0);
        run_poll("tie", 0);
        add(1, 3, 0); add(1, 2, 0); add(1, 1, 0); add(1, 0, 0);
        run_poll("fail", 1);

        add(1, 2, 1);
        run_poll("timeout", 0);

        add(1, 1, 1); add(1, 1, 0); add(0, 0, 0); add(1, 0, 1); add(1, 2, 0); add(1, 3, 1);
        run_poll("dup", 2);

        // Reset in the middle of a poll discards it.
        vif.start = 1'b1;
        tick();
        vif.start = 1'b0;
        vif.ballot_valid = 1'b1; vif.ballot_id = 2'd0; vif.ballot_yes = 1'b1;
        tick();
        vif.ballot_id = 2'd3;
        tick();
        idle_inputs();
        check("midreset.pre_cast", 32'(vif.cast), 32'(4'b1001));
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        #2;
        rst_n = 1'b1;
        tick();
        check_all_zero("midreset.release");
        add(1, 3, 1); add(1, 1, 1); add(1, 0, 1); add(1, 2, 1);
        run_poll("fresh", 0);

        for (int p = 0; p < 8; p++) begin
            int n = $urandom_range(0, 20);
            for (int k = 0; k < n; k++) begin
                add(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
            end
            run_poll($sformatf("rand%0d", p), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
